// File: rtl/width_packer.sv
// Packs RATIO narrow beats into one wide word and queues it in a DEPTH-entry FWFT line memory.
// Output valid the cycle after the completing beat; input stalls whenever the line memory is full.
module width_packer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IN_W*RATIO-1:0]        out_data,
    output logic [RATIO-1:0]             out_keep,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         flag
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int IW    = $clog2(RATIO);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = OUT_W + RATIO;
    localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

    logic [IW-1:0]    idx_q, idx_d;
    logic [OUT_W-1:0] pack_q, pack_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             flag_q;
    logic [EW-1:0]    mem_q [DEPTH];

    logic [IW-1:0]    lane;
    logic [OUT_W-1:0] word;
    logic [RATIO-1:0] word_keep;
    logic [EW-1:0]    head;
    logic             accept, complete, push, pop;

    assign in_ready  = rst_n && (count_q < CW'(DEPTH));
    assign out_valid = rst_n && (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign complete  = (idx_q == LAST_IDX) || in_last;
    assign push      = accept && complete;
    assign pop       = out_valid && out_ready;

    // Beat k lands in lane RATIO-1-k when MSB_FIRST, otherwise in lane k.
    assign lane = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;

    always_comb begin
        word      = pack_q;
        word_keep = keep_q;
        for (int l = 0; l < RATIO; l++) begin
            if (lane == IW'(l)) begin
                word[l*IN_W +: IN_W] = in_data;
                word_keep[l]         = 1'b1;
            end
        end
    end

    always_comb begin
        idx_d  = idx_q;
        pack_d = pack_q;
        keep_d = keep_q;
        if (accept) begin
            if (complete) begin
                idx_d  = '0;
                pack_d = '0;
                keep_d = '0;
            end else begin
                idx_d  = idx_q + 1'b1;
                pack_d = word;
                keep_d = word_keep;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            pack_q  <= '0;
            keep_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            pack_q  <= pack_d;
            keep_q  <= keep_d;
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (accept) flag_q <= in_data[IN_W-1];
        end
    end

    // Storage needs no reset: reads are masked until count says an entry is live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {word, word_keep};
    end

    assign head     = mem_q[rptr_q];
    assign out_data = out_valid ? head[EW-1:RATIO] : '0;
    assign out_keep = out_valid ? head[RATIO-1:0]  : '0;
    assign count    = count_q;
    assign flag     = flag_q;

endmodule

// File: tb/tb_width_packer.sv
// Drives an MSB-first and an LSB-first packer from the same stimulus and scoreboards both.
module tb_width_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic       in_ready_a, out_valid_a, flag_a, in_ready_b, out_valid_b, flag_b;
    logic [15:0] out_data_a, out_data_b;
    logic [1:0]  out_keep_a, out_keep_b;
    logic [2:0]  count_a, count_b;

    width_packer #(.IN_W(8), .RATIO(2), .DEPTH(4), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_keep(out_keep_a), .count(count_a), .flag(flag_a));

    width_packer #(.IN_W(8), .RATIO(2), .DEPTH(4), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_keep(out_keep_b), .count(count_b), .flag(flag_b));

    typedef struct {
        logic [15:0] dm; logic [1:0] km;
        logic [15:0] dl; logic [1:0] kl;
    } exp_t;

    typedef struct {
        logic [7:0]  b0; logic last0;
        logic [7:0]  b1; logic last1;
        logic [15:0] exp_m; logic [1:0] keep_m;
        logic [15:0] exp_l; logic [1:0] keep_l;
        logic        exp_flag;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 0;
    int   mdl_cnt = 0;
    int   mdl_idx = 0;
    logic mdl_flag = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(logic [7:0] b0, logic [7:0] b1);
        exp_t e;
        e.dm = {b0, b1}; e.km = 2'b11;
        e.dl = {b1, b0}; e.kl = 2'b11;
        q.push_back(e);
    endfunction

    // Scoreboard: observe pre-edge values on the falling edge, then advance the model.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   do_pop, do_push;
            exp_t e;
            chk("count_a", 32'(count_a), 32'(mdl_cnt));
            chk("count_b", 32'(count_b), 32'(mdl_cnt));
            chk("in_ready", 32'(in_ready_a), 32'(rst_n && mdl_cnt < 4));
            chk("in_ready_b", 32'(in_ready_b), 32'(rst_n && mdl_cnt < 4));
            chk("out_valid", 32'(out_valid_a), 32'(rst_n && mdl_cnt != 0));
            chk("out_valid_b", 32'(out_valid_b), 32'(rst_n && mdl_cnt != 0));
            chk("flag", 32'(flag_a), 32'(mdl_flag));
            chk("flag_b", 32'(flag_b), 32'(mdl_flag));
            if (!rst_n) begin
                q.delete();
                mdl_cnt  = 0;
                mdl_idx  = 0;
                mdl_flag = 1'b0;
            end else begin
                do_pop  = (mdl_cnt != 0) && out_ready;
                do_push = 1'b0;
                if (do_pop) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL pop_empty: got word %h, required no word", out_data_a);
                    end else begin
                        e = q.pop_front();
                        chk("data_msb", 32'(out_data_a), 32'(e.dm));
                        chk("keep_msb", 32'(out_keep_a), 32'(e.km));
                        chk("data_lsb", 32'(out_data_b), 32'(e.dl));
                        chk("keep_lsb", 32'(out_keep_b), 32'(e.kl));
                    end
                end
                if (in_valid && mdl_cnt < 4) begin
                    mdl_flag = in_data[7];
                    if (mdl_idx == 1 || in_last) begin
                        do_push = 1'b1;
                        mdl_idx = 0;
                    end else begin
                        mdl_idx = 1;
                    end
                end
                mdl_cnt = mdl_cnt + int'(do_push) - int'(do_pop);
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        bit acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got no in_ready, required accept of beat %h", d);
        end
    endtask

    task automatic wait_drain();
        int i = 0;
        while ((mdl_cnt != 0 || q.size() != 0) && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        if (i >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", q.size());
        end
    endtask

    vec_t tbl[5];
    bit   done4;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 8'h3C, 1'b0, 16'hA53C, 2'b11, 16'h3CA5, 2'b11, 1'b0};
        tbl[1] = '{8'h7E, 1'b1, 8'h00, 1'b0, 16'h7E00, 2'b10, 16'h007E, 2'b01, 1'b0};
        tbl[2] = '{8'h11, 1'b0, 8'h22, 1'b0, 16'h1122, 2'b11, 16'h2211, 2'b11, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 8'hFF, 1'b0, 16'h00FF, 2'b11, 16'hFF00, 2'b11, 1'b1};
        tbl[4] = '{8'h12, 1'b0, 8'h34, 1'b1, 16'h1234, 2'b11, 16'h3412, 2'b11, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count_a), 0);
        chk("rst_out_valid", 32'(out_valid_a), 0);
        chk("rst_in_ready", 32'(in_ready_a), 0);
        chk("rst_flag", 32'(flag_a), 0);
        chk("rst_out_data", 32'(out_data_a), 0);
        chk("rst_out_keep", 32'(out_keep_a), 0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table: full words, early in_last, and in_last on the final lane.
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.dm = tbl[i].exp_m; e.km = tbl[i].keep_m;
            e.dl = tbl[i].exp_l; e.kl = tbl[i].keep_l;
            q.push_back(e);
            send_beat(tbl[i].b0, tbl[i].last0);
            if (!tbl[i].last0) send_beat(tbl[i].b1, tbl[i].last1);
            chk("tbl_valid_next_cycle", 32'(out_valid_a), 1);
            chk("tbl_flag", 32'(flag_a), 32'(tbl[i].exp_flag));
        end
        wait_drain();

        // Fill to capacity with no consumer; a further beat must wait.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_exp(8'(8'h40 + 2*i), 8'(8'h41 + 2*i));
            send_beat(8'(8'h40 + 2*i), 1'b0);
            send_beat(8'(8'h41 + 2*i), 1'b0);
        end
        chk("full_count", 32'(count_a), 4);
        chk("full_in_ready", 32'(in_ready_a), 0);
        push_exp(8'hC1, 8'hC2);
        fork
            begin
                send_beat(8'hC1, 1'b0);
                send_beat(8'hC2, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("held_count", 32'(count_a), 4);
                chk("held_in_ready", 32'(in_ready_a), 0);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Ten words with the consumer toggling ready every cycle; pointers wrap.
        done4 = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [7:0] b0, b1;
                    b0 = 8'($urandom_range(0, 255));
                    b1 = 8'($urandom_range(0, 255));
                    push_exp(b0, b1);
                    send_beat(b0, 1'b0);
                    send_beat(b1, 1'b0);
                end
                done4 = 1'b1;
            end
            begin
                for (int i = 0; i < 400 && !done4; i++) begin
                    out_ready = ~out_ready;
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Completing beat and pop on the same edge with two words stored.
        out_ready = 1'b0;
        push_exp(8'h01, 8'h02); send_beat(8'h01, 1'b0); send_beat(8'h02, 1'b0);
        push_exp(8'h03, 8'h04); send_beat(8'h03, 1'b0); send_beat(8'h04, 1'b0);
        push_exp(8'hA5, 8'h3C);
        send_beat(8'hA5, 1'b0);
        chk("pp_count_before", 32'(count_a), 2);
        out_ready = 1'b1;
        send_beat(8'h3C, 1'b0);
        chk("pp_count_after", 32'(count_a), 2);
        chk("pp_head_msb", 32'(out_data_a), 32'h0304);
        wait_drain();

        // Reset with a stored word and a half-packed word discards both.
        out_ready = 1'b0;
        push_exp(8'h55, 8'h66);
        send_beat(8'h55, 1'b0); send_beat(8'h66, 1'b0);
        send_beat(8'h80, 1'b0);
        chk("pre_rst_flag", 32'(flag_a), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_flag", 32'(flag_a), 0);
        chk("post_rst_count", 32'(count_a), 0);
        chk("post_rst_valid", 32'(out_valid_a), 0);
        out_ready = 1'b1;
        push_exp(8'h01, 8'h02);
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        chk("post_rst_word", 32'(out_data_a), 32'h0102);
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
